// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment display path.
// The driver and the capture side both import this, so their patterns agree.
package sseg_pkg;

  localparam int DIGITS = 4;

  // Active-low segment patterns, ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Per-digit capture state
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } st_t;

endpackage

// File: rtl/sseg_decode.sv
// Combinational segment-pattern decoder: 7-bit active-low pattern to a hex nibble.
// Unknown patterns report valid = 0 and nibble = 0.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  // Table lookup against the shared segment constants
  always_comb begin
    valid  = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_capture.sv
// Rebuilds the 16-bit hex value shown on a multiplexed four-digit display
// by watching its anode/segment/dp lines on the shared clock.
module sseg_capture
  import sseg_pkg::*;
#(
  parameter int SETTLE       = 4,
  parameter int IDLE_TIMEOUT = 2**20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  sseg,
  input  logic        dp,
  output logic [15:0] data,
  output logic [3:0]  dp_bits,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        anode_err,
  output logic        link_lost
);

  localparam int CW = 8;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] SETTLE_C   = CW'(SETTLE);
  localparam logic [IW-1:0] TIMEOUT_C  = IW'(IDLE_TIMEOUT);
  localparam logic [IW-1:0] TIMEOUT_M1 = IW'(IDLE_TIMEOUT - 1);

  logic [3:0]    an_q;
  logic [6:0]    sseg_q;
  logic          dp_q;
  logic [1:0]    prev_idx_reg;
  logic [6:0]    prev_sseg_reg;
  logic          prev_dp_reg;
  st_t           st_reg, st_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [IW-1:0] idle_cnt_reg;
  logic [3:0]    mask_reg, mask_next;
  logic          err_acc_reg, err_next;
  logic [4:0]    slot_reg [DIGITS];   // {dp lit, nibble} per digit
  logic [15:0]   shadow_flat;
  logic [3:0]    dp_flat;
  logic [15:0]   data_reg;
  logic [3:0]    dp_bits_reg;
  logic          frame_valid_reg, frame_err_reg, anode_err_reg, link_lost_reg;

  logic          idx_valid, multi_low, same_sample, latch, commit, timeout;
  logic [1:0]    idx;
  logic          dec_valid;
  logic [3:0]    dec_nibble;

  sseg_decode u_decode (
    .seg    (sseg_q),
    .valid  (dec_valid),
    .nibble (dec_nibble)
  );

  // Input register stage; the source shares clk so no synchronizer is needed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q          <= 4'hF;
      sseg_q        <= 7'h7F;
      dp_q          <= 1'b1;
      prev_idx_reg  <= 2'd0;
      prev_sseg_reg <= 7'h7F;
      prev_dp_reg   <= 1'b1;
    end else begin
      an_q          <= an;
      sseg_q        <= sseg;
      dp_q          <= dp;
      prev_idx_reg  <= idx;
      prev_sseg_reg <= sseg_q;
      prev_dp_reg   <= dp_q;
    end
  end

  // Anode index: exactly one low bit selects a digit, several low is an error
  always_comb begin
    idx_valid = 1'b0;
    idx       = 2'd0;
    multi_low = 1'b0;
    case (an_q)
      4'b1110: begin idx_valid = 1'b1; idx = 2'd0; end
      4'b1101: begin idx_valid = 1'b1; idx = 2'd1; end
      4'b1011: begin idx_valid = 1'b1; idx = 2'd2; end
      4'b0111: begin idx_valid = 1'b1; idx = 2'd3; end
      4'b1111: begin idx_valid = 1'b0; end
      default: begin multi_low = 1'b1; end
    endcase
  end

  assign same_sample = (idx == prev_idx_reg) && (sseg_q == prev_sseg_reg) && (dp_q == prev_dp_reg);
  assign commit      = (mask_reg == 4'hF);
  assign timeout     = !idx_valid && (idle_cnt_reg == TIMEOUT_M1);

  // Settle FSM next state; the latch fires on the sample that completes the stable run
  always_comb begin
    st_next  = st_reg;
    cnt_next = cnt_reg;
    latch    = 1'b0;
    case (st_reg)
      ST_IDLE: begin
        if (idx_valid) begin
          cnt_next = CW'(1);
          st_next  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!idx_valid)       st_next  = ST_IDLE;
        else if (same_sample) cnt_next = cnt_reg + CW'(1);
        else                  cnt_next = CW'(1);
      end
      ST_HOLD: begin
        if (!idx_valid) begin
          st_next = ST_IDLE;
        end else if (idx != prev_idx_reg) begin
          cnt_next = CW'(1);
          st_next  = ST_SETTLE;
        end
      end
      default: st_next = ST_IDLE;
    endcase
    if (st_next == ST_SETTLE && cnt_next == SETTLE_C) begin
      latch   = 1'b1;
      st_next = ST_HOLD;
    end
  end

  // FSM state and settle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_reg  <= ST_IDLE;
      cnt_reg <= '0;
    end else begin
      st_reg  <= st_next;
      cnt_reg <= cnt_next;
    end
  end

  // Idle counter saturates so the timeout fires once per idle period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         idle_cnt_reg <= '0;
    else if (idx_valid)                 idle_cnt_reg <= '0;
    else if (idle_cnt_reg != TIMEOUT_C) idle_cnt_reg <= idle_cnt_reg + IW'(1);
  end

  // Frame mask and error accumulator; a latch in the commit cycle starts the next frame
  always_comb begin
    mask_next = commit ? 4'h0 : mask_reg;
    err_next  = commit ? 1'b0 : err_acc_reg;
    if (latch) begin
      mask_next[idx] = 1'b1;
      if (!dec_valid) err_next = 1'b1;
    end
    if (timeout) begin
      mask_next = 4'h0;
      err_next  = 1'b0;
    end
  end

  // Per-digit shadow slots
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
      // Capture decoded nibble and dp for this digit; wiped on idle timeout
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            slot_reg[gi] <= '0;
        else if (timeout)                      slot_reg[gi] <= '0;
        else if (latch && idx == 2'(gi))       slot_reg[gi] <= {!dp_q, dec_nibble};
      end
      assign shadow_flat[4*gi +: 4] = slot_reg[gi][3:0];
      assign dp_flat[gi]            = slot_reg[gi][4];
    end
  endgenerate

  // Frame publish, sticky anode error and link status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_reg        <= 4'h0;
      err_acc_reg     <= 1'b0;
      data_reg        <= 16'h0;
      dp_bits_reg     <= 4'h0;
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      anode_err_reg   <= 1'b0;
      link_lost_reg   <= 1'b0;
    end else begin
      mask_reg        <= mask_next;
      err_acc_reg     <= err_next;
      frame_valid_reg <= commit;
      if (commit) begin
        data_reg      <= shadow_flat;
        dp_bits_reg   <= dp_flat;
        frame_err_reg <= err_acc_reg;
      end
      if (multi_low) anode_err_reg <= 1'b1;
      if (timeout)   link_lost_reg <= 1'b1;
      else if (latch) link_lost_reg <= 1'b0;
    end
  end

  assign data        = data_reg;
  assign dp_bits     = dp_bits_reg;
  assign frame_valid = frame_valid_reg;
  assign frame_err   = frame_err_reg;
  assign anode_err   = anode_err_reg;
  assign link_lost   = link_lost_reg;

endmodule

// File: tb/tb_sseg_capture.sv
// Directed bench for sseg_capture with a sample-history reference model
// compared every cycle, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_sseg_capture;

  localparam int SETTLE = 4;
  localparam int TMO    = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  sseg = 7'h7F;
  logic        dp = 1'b1;
  logic [15:0] data;
  logic [3:0]  dp_bits;
  logic        frame_valid, frame_err, anode_err, link_lost;

  always #5 clk = ~clk;

  sseg_capture #(.SETTLE(SETTLE), .IDLE_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .sseg        (sseg),
    .dp          (dp),
    .data        (data),
    .dp_bits     (dp_bits),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .anode_err   (anode_err),
    .link_lost   (link_lost)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Hex digit to active-low {g..a} pattern, written from the segment chart
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Works on the history of registered samples: a digit is taken when the
  // last SETTLE samples are identical and nothing was taken yet since the
  // anode last changed; four taken digits make a frame one cycle later.
  logic [3:0]  s_an;
  logic [6:0]  s_sseg;
  logic        s_dp;
  logic [10:0] prev_key;
  int          run, idle_run;
  bit          stretch_done;
  logic [3:0]  sh [4];
  logic [3:0]  m_dpsh, m_mask, m_dpb;
  logic [15:0] m_data;
  logic        m_err, m_fv, m_fe, m_aerr, m_ll;

  task automatic model_reset();
    s_an = 4'hF; s_sseg = 7'h7F; s_dp = 1'b1;
    prev_key = '0; run = 0; idle_run = 0; stretch_done = 0;
    for (int i = 0; i < 4; i++) sh[i] = 4'h0;
    m_dpsh = 0; m_mask = 0; m_dpb = 0; m_data = 0;
    m_err = 0; m_fv = 0; m_fe = 0; m_aerr = 0; m_ll = 0;
  endtask

  task automatic model_step();
    int zeros;
    logic v, ok, take;
    logic [1:0] ix;
    logic [3:0] nib;
    logic [10:0] key;
    zeros = 0; ix = 0;
    for (int i = 0; i < 4; i++) if (!s_an[i]) begin zeros++; ix = 2'(i); end
    v = (zeros == 1);
    if (zeros > 1) m_aerr = 1'b1;
    key = {v, ix, s_sseg, s_dp};
    if (v && key == prev_key) run++;
    else run = v ? 1 : 0;
    if (!v || !prev_key[10] || ix != prev_key[9:8]) stretch_done = 0;
    take = v && (run == SETTLE) && !stretch_done;
    if (take) stretch_done = 1;
    m_fv = (m_mask == 4'hF);
    if (m_fv) begin
      m_data = {sh[3], sh[2], sh[1], sh[0]};
      m_dpb = m_dpsh; m_fe = m_err; m_mask = 0; m_err = 0;
    end
    if (take) begin
      ok = 0; nib = 0;
      for (int n = 0; n < 16; n++) if (seg_of(4'(n)) == s_sseg) begin ok = 1; nib = 4'(n); end
      sh[ix] = nib; m_dpsh[ix] = !s_dp; m_mask[ix] = 1'b1;
      if (!ok) m_err = 1'b1;
      m_ll = 1'b0;
    end
    if (!v) begin
      if (idle_run < TMO) begin
        idle_run++;
        if (idle_run == TMO) begin
          m_mask = 0; m_err = 0; m_dpsh = 0; m_ll = 1'b1;
          for (int i = 0; i < 4; i++) sh[i] = 4'h0;
        end
      end
    end else begin
      idle_run = 0;
    end
    prev_key = key;
    s_an = an; s_sseg = sseg; s_dp = dp;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  // ---------------- per-cycle compare ----------------
  bit          cmp_en = 0;
  int          fcount = 0;
  logic [15:0] last_data = 0;
  logic [3:0]  last_dpb = 0;
  logic        last_fe = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cycle",
          {8'h0, data, dp_bits, frame_valid, frame_valid & frame_err, anode_err, link_lost},
          {8'h0, m_data, m_dpb, m_fv, m_fv & m_fe, m_aerr, m_ll});
      if (frame_valid) begin
        fcount++;
        last_data = data; last_dpb = dp_bits; last_fe = frame_err;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic show(input int idx, input logic [6:0] pat, input logic dpl, input int n);
    an = ~(4'b0001 << idx); sseg = pat; dp = dpl;
    cyc(n);
  endtask

  task automatic scan(input logic [15:0] val, input logic [3:0] dpm, input int dwell);
    for (int d = 3; d >= 0; d--) show(d, seg_of(val[4*d +: 4]), !dpm[d], dwell);
  endtask

  int f0;

  initial begin
    reset = 1'b0;
    cyc(3);
    cmp_en = 1;
    chk("reset_outputs", {26'h0, frame_valid, frame_err, anode_err, link_lost, dp_bits != 0, data != 0}, 32'h0);
    reset = 1'b1;
    cyc(2);

    // Plain scan, long dwell
    f0 = fcount;
    scan(16'h1234, 4'b0000, 1000);
    chk("s1234_frames", 32'(fcount - f0), 32'd1);
    chk("s1234_data", 32'(last_data), 32'h1234);
    chk("s1234_model", 32'(m_data), 32'h1234);
    chk("s1234_ferr", 32'(last_fe), 32'd0);
    chk("s1234_dp", 32'(last_dpb), 32'd0);

    // Decimal point on digit 2
    f0 = fcount;
    scan(16'hABCD, 4'b0100, 60);
    chk("sABCD_frames", 32'(fcount - f0), 32'd1);
    chk("sABCD_data", 32'(last_data), 32'hABCD);
    chk("sABCD_dp", 32'(last_dpb), 32'b0100);

    // Undecodable pattern on digit 1
    f0 = fcount;
    show(3, seg_of(4'h9), 1'b1, 60);
    show(2, seg_of(4'h8), 1'b1, 60);
    show(1, 7'b1010101, 1'b1, 60);
    show(0, seg_of(4'h6), 1'b1, 60);
    chk("bad_frames", 32'(fcount - f0), 32'd1);
    chk("bad_data", 32'(last_data), 32'h9806);
    chk("bad_ferr", 32'(last_fe), 32'd1);

    // Short glitch before the steady digit 0
    f0 = fcount;
    show(3, seg_of(4'h5), 1'b1, 60);
    show(2, seg_of(4'h5), 1'b1, 60);
    show(1, seg_of(4'h5), 1'b1, 60);
    show(0, seg_of(4'h8), 1'b1, 2);
    show(0, seg_of(4'h5), 1'b1, 60);
    chk("glitch_frames", 32'(fcount - f0), 32'd1);
    chk("glitch_data", 32'(last_data), 32'h5555);
    chk("glitch_ferr", 32'(last_fe), 32'd0);

    // Two anodes low for one cycle
    an = 4'b1100; cyc(1);
    cyc(2);
    chk("anode_err_set", 32'(anode_err), 32'd1);
    f0 = fcount;
    scan(16'h4321, 4'b0000, 60);
    chk("after_aerr_frames", 32'(fcount - f0), 32'd1);
    chk("after_aerr_data", 32'(last_data), 32'h4321);
    chk("anode_err_sticky", 32'(anode_err), 32'd1);

    // Idle timeout after a partial frame
    f0 = fcount;
    show(3, seg_of(4'h7), 1'b1, 60);
    show(2, seg_of(4'h7), 1'b1, 60);
    an = 4'hF; sseg = 7'h7F; cyc(TMO + 10);
    chk("timeout_link_lost", 32'(link_lost), 32'd1);
    chk("timeout_no_frame", 32'(fcount - f0), 32'd0);
    chk("timeout_data_kept", 32'(data), 32'h4321);
    scan(16'h00FF, 4'b0000, 60);
    chk("recover_frames", 32'(fcount - f0), 32'd1);
    chk("recover_data", 32'(last_data), 32'h00FF);
    chk("recover_link", 32'(link_lost), 32'd0);

    // Reset mid-scan
    show(3, seg_of(4'h1), 1'b1, 60);
    show(2, seg_of(4'h2), 1'b1, 60);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_data", 32'(data), 32'h0);
    chk("midreset_flags", {27'h0, dp_bits != 0, frame_valid, frame_err, anode_err, link_lost}, 32'h0);
    cyc(3);
    reset = 1'b1;
    f0 = fcount;
    scan(16'h2468, 4'b1000, 60);
    chk("post_reset_frames", 32'(fcount - f0), 32'd1);
    chk("post_reset_data", 32'(last_data), 32'h2468);
    chk("post_reset_dp", 32'(last_dpb), 32'b1000);
    chk("post_reset_aerr", 32'(anode_err), 32'd0);

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sseg_capture.md
# sseg_capture

Receiving end of the multiplexed seven-segment interface: watches the `an`/`sseg`/`dp` lines driven by the four-digit display driver and rebuilds the 16-bit hex value that is on screen. It sits beside the display on the same `clk`, either as a loop-back monitor in the top level or in the verification harness. For each anode it waits for the bus to be stable, decodes the segment pattern to a nibble, and assembles a frame once all four digits are seen. It publishes the frame with a one-cycle strobe and error flags.

## Interface
- `SETTLE`, default 4: number of consecutive identical registered samples required before a digit is latched (range 1–255).
- `IDLE_TIMEOUT`, default 2**20: cycles with no valid anode before the partial frame is discarded and `link_lost` is raised.
- `clk` in 1: system clock, the same clock that drives the display driver.
- `reset` in 1: asynchronous, active-low reset.
- `an` in 4: anode enables, active-low; bit 0 is the rightmost digit and maps to `data[3:0]`.
- `sseg` in 7: segments, active-low, ordered {g,f,e,d,c,b,a}.
- `dp` in 1: decimal point, active-low.
- `data` out 16: last complete frame; digit k occupies bits [4k+3:4k].
- `dp_bits` out 4: decimal-point state per digit in the last frame; 1 means lit.
- `frame_valid` out 1: one-cycle strobe when `data` and `dp_bits` update.
- `frame_err` out 1: valid only with `frame_valid`; set if any digit in the frame held an undecodable pattern.
- `anode_err` out 1: sticky; set when more than one anode is low in any registered sample. Cleared only by reset.
- `link_lost` out 1: level; high after the idle timeout, low again on the next latched digit.

## Operation
- Inputs pass through one register stage, `an_q`, `sseg_q` and `dp_q`. All logic runs on the registered values. There is no synchronizer, because the source shares `clk`.
- The anode index comes from `an_q`:
  - One-hot-low gives index 0–3.
  - All high means no digit.
  - More than one low means no digit and sets `anode_err`.
- State machine `st`:
  - `IDLE`: no valid anode. Go to `SETTLE` when a valid anode appears, and load `cnt` = 1.
  - `SETTLE`: if {index, `sseg_q`, `dp_q`} equals the previous sample, increment `cnt`. Otherwise reload `cnt` = 1, or go to `IDLE` if the anode becomes invalid. When `cnt` reaches `SETTLE`, latch the digit and go to `HOLD`.
  - `HOLD`: digit already latched. Stay while the index is unchanged, even if segments change. On a different valid index go to `SETTLE` with `cnt` = 1. On an invalid anode go to `IDLE`.
- Digit latch:
  - Decode `sseg_q` to a nibble, write it to the `shadow` slot for the current index, set that index's `mask` bit, and record `!dp_q`.
  - Decode patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Any other pattern stores nibble 0 and sets sticky `err_acc`.
  - Re-latching an index already in `mask` overwrites its slot.
- Frame commit:
  - The cycle after `mask` becomes 4'b1111: copy `shadow` to `data` and the dp bits to `dp_bits`, pulse `frame_valid`, drive `frame_err` = `err_acc`.
  - In the same cycle clear `mask` and `err_acc`.
  - A latch that happens in the commit cycle belongs to the next frame.
- Idle timeout:
  - `idle_cnt` counts cycles spent in `IDLE` and saturates at `IDLE_TIMEOUT`.
  - On reaching `IDLE_TIMEOUT`: clear `mask`, `err_acc` and `shadow`, and set `link_lost`.
  - `data` keeps its last value.

## Timing
- Reset values: `data` = 0, `dp_bits` = 0, `frame_valid` = 0, `frame_err` = 0, `anode_err` = 0, `link_lost` = 0, `st` = `IDLE`, `mask` = 0. The input registers reset to `an_q` = 4'hF, `sseg_q` = 7'h7F, `dp_q` = 1.
- Latch latency: an anode change on the input pins at edge t is visible in `an_q` at t+1. With stable segments the digit latches at edge t+`SETTLE`.
- Commit latency: `frame_valid` is high for the cycle following the fourth latch edge, and `data` changes on that same edge.
- Glitches shorter than `SETTLE` cycles are never latched.
- Reset asserted mid-frame clears all state immediately. Capture resumes on the first valid anode after reset is released.

## Structure
- Shared package `sseg_pkg`: the 16 segment constants (`SEG_0`..`SEG_F`), the `st` encoding (`ST_IDLE`, `ST_SETTLE`, `ST_HOLD`), and the `DIGITS` = 4 constant. The display driver imports the same constants, so both ends agree by construction.
- Sub-module `sseg_decode`: combinational, 7-bit pattern in, {valid, nibble} out. The capture block instantiates it once.

## Test plan
- Scan 0x1234, with each anode held 1000 cycles, no dp, `SETTLE`=4 → `frame_valid` pulses once per full scan, `data`=16'h1234, `frame_err`=0, `dp_bits`=0.
- Scan 0xABCD with the dp low on digit 2 → `data`=16'hABCD, `dp_bits`=4'b0100.
- While digit 1 is active, drive `sseg`=7'b1010101 for the full dwell → `frame_err`=1 with `frame_valid`, `data[7:4]`=0.
- Inject a 2-cycle segment glitch on digit 0 of 0x5555, then the steady "5" pattern → glitch ignored, `data`=16'h5555.
- Drive `an`=4'b1100 for one cycle → `anode_err`=1 and stays 1; subsequent valid scans still commit correctly.
- Hold `an`=4'hF for `IDLE_TIMEOUT` cycles after two digits latch → `link_lost`=1, no `frame_valid`; the next full scan of 0x00FF gives `data`=16'h00FF and `link_lost`=0. Assert reset mid-scan → all outputs return to their reset values.
